sap_sequencer: RTL and testbench
================================

Name: sap_sequencer

Overview:
- Microsequencer for the SAP-1 add/sub datapath (PC, MAR, ROM, IR, A, B, C, ALU, Output).
- Runs a 6-state T-cycle ring counter (T1..T6). Decodes the IR opcode into the 16-bit control word `con`.
- Adds HLT handling, free-run / single-step execution and status outputs. Drop-in alternative sequencer for the `con` bus.

Parameters:
- CW_W, 16, control word width; fixed bit order, see Behaviour.
- OP_W, 4, opcode width from IR.
- NT, 6, number of T-states; ring length; one-hot width of `t_state`.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- CLR  input  1  reset, asynchronous, active-low.
- opcode  input  OP_W  IR upper nibble; valid from T4 onward.
- run  input  1  1 = free-run, 0 = single-step mode.
- step  input  1  synchronous level; each rising edge grants one T-state in step mode.
- con  output  CW_W  control word `{CP,EP,Lm_,CE_,Li_,ei_,La_,ea,eb,ec,Su[1:0],Eu,Lb_,Lc_,Lo_}`, with bit15 = CP and bit0 = Lo_.
- t_state  output  NT  one-hot current T-state; bit0 = T1.
- halted  output  1  HLT executed; sequencer frozen.

Behaviour:
- **Reset (CLR=0, asynchronous)**
  - State goes to T1 and `halted`=0. The `step` edge-detect register is cleared.
  - While CLR=0, `con` is forced to NOP `16'h3E07` and `t_state`=`6'b000001`.
  - Reset mid-instruction aborts the instruction with no further loads.
- **Advance qualifier**
  - `adv` = CLR & ~halted & (run | step_rise), where step_rise = step & ~step_q.
  - When `adv`=1, the state moves Tn→Tn+1 at posedge, and T6→T1.
  - When `adv`=0, the state holds and `con`=`16'h3E07`. This stops CP, loads and enables repeating during a stall.
- **Control word timing**
  - `con` = combinational decode of (state, opcode), valid only in cycles where `adv`=1.
  - Destination registers load at the posedge that ends the T-state.
- **Fetch, all opcodes**
  - T1: EP, Lm_ → `5E07`.
  - T2: CP → `BE07`.
  - T3: CE_, Li_ → `2607`.
- **Execute**
  - LDA (`0000`): T4 ei_, Lm_ → `1A07`; T5 CE_, La_ → `2C07`; T6 NOP `3E07`.
  - ADD (`0001`): T4 `1A07`; T5 CE_, Lb_ → `2E03`; T6 Eu, La_, Su=00 → `3C0F`.
  - SUB (`0010`): T4 `1A07`; T5 `2E03`; T6 Eu, La_, Su=01 → `3C1F`.
  - OUT (`1110`): T4 ea, Lo_ → `3F06`; T5 and T6 NOP.
  - HLT (`1111`): T4 emits NOP. At the posedge ending T4 (when `adv`=1), `halted` is set and the state stays at T4. Thereafter `con`=`3E07` permanently. Only CLR exits HLT; `run` and `step` are ignored.
  - Undefined opcodes: T4–T6 NOP, then the next fetch proceeds.
- **Boundary cases**
  - `step` held high counts as one edge only.
  - A step edge while `run`=1 is redundant; there is no double advance.
  - Switching `run` from 1 to 0 mid-instruction freezes at the current T-state. The next step edge resumes exactly there.
  - `opcode` changes outside T4–T6 have no effect.

Decomposition:
- **Package `sap_pkg`**
  - Opcode constants: OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT.
  - Control-bit index constants: CW_CP=15 … CW_LO_=0.
  - Named control words: CW_NOP=`3E07`, CW_T1, CW_T2, CW_T3, CW_LDA_T4, CW_LDA_T5, CW_ADD_T5, CW_ADD_T6, CW_SUB_T6, CW_OUT_T4.
  - ALU select constants: SU_ADD=00, SU_SUB=01.
- **Sub-module `sap_step_ctrl`**
  - Contains the step edge detect and the `adv` generation.
  - Inputs: CLK, CLR, run, step, halted. Output: `adv`.
- The main module holds the ring counter, HLT latch and decode.

Test Plan:
- Reset and free-run: CLR low, then high, run=1, opcode=`0000` → `con` sequence `5E07`, `BE07`, `2607`, `1A07`, `2C07`, `3E07`, then back to `5E07`; `t_state` one-hot `01`, `02`, `04`, `08`, `10`, `20`, `01`.
- ADD then SUB: opcode=`0001` gives T6 `con`=`3C0F`; next instruction opcode=`0010` gives T6 `con`=`3C1F`; T5 is `2E03` in both.
- OUT and HLT: opcode=`1110` gives T4 `3F06`. Next, opcode=`1111` → `halted`=1 after T4, `t_state`=`08` held, `con`=`3E07` for 20+ cycles despite run=1 and step pulses.
- Single-step: run=0 → `con`=`3E07` and state frozen. A 3-cycle step pulse advances exactly one T-state, with the active word present for exactly one cycle.
- Async reset mid-execute: CLR low between clock edges during ADD T5 → immediately `con`=`3E07`, `t_state`=`01`, `halted`=0. Release → `5E07` on the first cycle.
- Undefined opcode `0111`: T4–T6 all `3E07`, then the next fetch is `5E07`.

Source files
------------

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared widths, opcodes, control-word layout and T-state encoding for the SAP-1 sequencer
package sap_pkg;

  localparam int CW_W = 16;
  localparam int OP_W = 4;
  localparam int NT   = 6;

  // Opcodes decoded from the IR upper nibble
  localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  // Bit positions inside the control word; names ending in _ are active-low
  localparam int CW_CP  = 15;
  localparam int CW_EP  = 14;
  localparam int CW_LM_ = 13;
  localparam int CW_CE_ = 12;
  localparam int CW_LI_ = 11;
  localparam int CW_EI_ = 10;
  localparam int CW_LA_ = 9;
  localparam int CW_EA  = 8;
  localparam int CW_EB  = 7;
  localparam int CW_EC  = 6;
  localparam int CW_SU1 = 5;
  localparam int CW_SU0 = 4;
  localparam int CW_EU  = 3;
  localparam int CW_LB_ = 2;
  localparam int CW_LC_ = 1;
  localparam int CW_LO_ = 0;

  // ALU function select carried in the Su field
  localparam logic [1:0] SU_ADD = 2'b00;
  localparam logic [1:0] SU_SUB = 2'b01;

  // Named control words: every active-low load/enable deasserted is the NOP
  localparam logic [CW_W-1:0] CW_NOP    = 16'h3E07;
  localparam logic [CW_W-1:0] CW_T1     = 16'h5E07;
  localparam logic [CW_W-1:0] CW_T2     = 16'hBE07;
  localparam logic [CW_W-1:0] CW_T3     = 16'h2607;
  localparam logic [CW_W-1:0] CW_LDA_T4 = 16'h1A07;
  localparam logic [CW_W-1:0] CW_LDA_T5 = 16'h2C07;
  localparam logic [CW_W-1:0] CW_ADD_T5 = 16'h2E03;
  localparam logic [CW_W-1:0] CW_ADD_T6 = 16'h3C0F;
  localparam logic [CW_W-1:0] CW_SUB_T6 = 16'h3C1F;
  localparam logic [CW_W-1:0] CW_OUT_T4 = 16'h3F06;

  // One-hot ring counter states, bit0 = T1
  typedef enum logic [NT-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

endpackage

// File: rtl/sap_sequencer_if.sv
// rtl/sap_sequencer_if.sv - opcode/mode inputs and control-word/status outputs of the sequencer
interface sap_sequencer_if
  import sap_pkg::*;
();

  logic [OP_W-1:0] opcode;
  logic            run;
  logic            step;
  logic [CW_W-1:0] con;
  logic [NT-1:0]   t_state;
  logic            halted;

  // Driver side: front panel and IR
  modport master (
    output opcode, run, step,
    input  con, t_state, halted
  );

  // Sequencer side
  modport slave (
    input  opcode, run, step,
    output con, t_state, halted
  );

endinterface

// File: rtl/sap_step_ctrl.sv
// rtl/sap_step_ctrl.sv - step edge detect and T-state advance qualifier
module sap_step_ctrl (
  input  logic CLK,
  input  logic CLR,
  input  logic run,
  input  logic step,
  input  logic halted,
  output logic adv
);

  logic step_d;
  logic step_q;

  // Track the previous step level so a held button counts once
  always_comb begin
    step_d = step;
  end

  // Edge-detect history register, cleared by reset
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_d;
    end
  end

  // Free-run advances every cycle; step mode advances only on a fresh rising edge
  assign adv = CLR & ~halted & (run | (step & ~step_q));

endmodule

// File: rtl/sap_sequencer.sv
// rtl/sap_sequencer.sv - SAP-1 microsequencer: T-state ring, HLT latch and control-word decode
module sap_sequencer
  import sap_pkg::*;
(
  input  logic           CLK,
  input  logic           CLR,
  sap_sequencer_if.slave bus
);

  t_state_e        state_d;
  t_state_e        state_q;
  logic            halted_d;
  logic            halted_q;
  logic            adv;
  logic [CW_W-1:0] cw;

  sap_step_ctrl u_step_ctrl (
    .CLK    (CLK),
    .CLR    (CLR),
    .run    (bus.run),
    .step   (bus.step),
    .halted (halted_q),
    .adv    (adv)
  );

  // Next T-state: rotate on advance, except HLT which parks at T4 and latches halted
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (adv) begin
      if (state_q == T4 && bus.opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else begin
        case (state_q)
          T1:      state_d = T2;
          T2:      state_d = T3;
          T3:      state_d = T4;
          T4:      state_d = T5;
          T5:      state_d = T6;
          T6:      state_d = T1;
          default: state_d = T1;
        endcase
      end
    end
  end

  // Ring counter and halt latch; reset aborts any instruction in flight
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Decode (T-state, opcode) into the control word for this T-state
  always_comb begin
    cw = CW_NOP;
    case (state_q)
      T1: cw = CW_T1;
      T2: cw = CW_T2;
      T3: cw = CW_T3;
      T4: begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB: cw = CW_LDA_T4;
          OP_OUT:                 cw = CW_OUT_T4;
          default:                cw = CW_NOP;
        endcase
      end
      T5: begin
        case (bus.opcode)
          OP_LDA:         cw = CW_LDA_T5;
          OP_ADD, OP_SUB: cw = CW_ADD_T5;
          default:        cw = CW_NOP;
        endcase
      end
      T6: begin
        case (bus.opcode)
          OP_ADD:  cw = CW_ADD_T6;
          OP_SUB:  cw = CW_SUB_T6;
          default: cw = CW_NOP;
        endcase
      end
      default: cw = CW_NOP;
    endcase
  end

  // Only a cycle that will actually advance may drive CP, enables or loads
  always_comb begin
    bus.con     = adv ? cw : CW_NOP;
    bus.t_state = state_q;
    bus.halted  = halted_q;
  end

endmodule

// File: tb/tb_sap_sequencer.sv
// tb/tb_sap_sequencer.sv - randomized self-checking bench for sap_sequencer against a behavioural model
module tb_sap_sequencer;

  logic CLK = 1'b0;
  logic CLR = 1'b0;

  sap_sequencer_if bus_if ();

  sap_sequencer dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus_if)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model state: T-state number 1..6, halt flag, previous step level
  int   m_t     = 1;
  logic m_halt  = 1'b0;
  logic m_stepq = 1'b0;

  logic [15:0] last_con;
  logic [5:0]  last_t;
  logic        last_h;
  logic [15:0] got_con [6];
  logic [5:0]  got_t   [6];
  logic [15:0] sc      [3];

  // Expected control word from the instruction table
  function automatic logic [15:0] exp_word(int t, logic [3:0] op);
    case (t)
      1: return 16'h5E07;
      2: return 16'hBE07;
      3: return 16'h2607;
      4: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) return 16'h1A07;
        if (op == 4'hE) return 16'h3F06;
        return 16'h3E07;
      end
      5: begin
        if (op == 4'h0) return 16'h2C07;
        if (op == 4'h1 || op == 4'h2) return 16'h2E03;
        return 16'h3E07;
      end
      6: begin
        if (op == 4'h1) return 16'h3C0F;
        if (op == 4'h2) return 16'h3C1F;
        return 16'h3E07;
      end
      default: return 16'h3E07;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance at each clock edge
  always @(posedge CLK) begin
    if (!CLR) begin
      m_t     <= 1;
      m_halt  <= 1'b0;
      m_stepq <= 1'b0;
    end else begin
      m_stepq <= bus_if.step;
      if (!m_halt && (bus_if.run || (bus_if.step && !m_stepq))) begin
        if (m_t == 4 && bus_if.opcode == 4'hF) m_halt <= 1'b1;
        else m_t <= (m_t == 6) ? 1 : m_t + 1;
      end
    end
  end

  task automatic compare_model();
    logic [15:0] ec;
    logic [5:0]  et;
    logic        eh;
    if (!CLR) begin
      ec = 16'h3E07;
      et = 6'b000001;
      eh = 1'b0;
    end else begin
      if (!m_halt && (bus_if.run || (bus_if.step && !m_stepq))) ec = exp_word(m_t, bus_if.opcode);
      else ec = 16'h3E07;
      et = 6'(1 << (m_t - 1));
      eh = m_halt;
    end
    chk("model_con", 32'(bus_if.con), 32'(ec));
    chk("model_t_state", 32'(bus_if.t_state), 32'(et));
    chk("model_halted", 32'(bus_if.halted), 32'(eh));
  endtask

  // One clock: check mid-cycle, then return just after the next posedge
  task automatic step_cycle();
    @(negedge CLK);
    #1;
    compare_model();
    last_con = bus_if.con;
    last_t   = bus_if.t_state;
    last_h   = bus_if.halted;
    @(posedge CLK);
    #2;
  endtask

  // Free-run one whole instruction starting at T1
  task automatic run_instr(logic [3:0] op);
    bus_if.opcode = op;
    for (int i = 0; i < 6; i++) begin
      step_cycle();
      got_con[i] = last_con;
      got_t[i]   = last_t;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lda_con [6];
    logic [5:0]  ring    [6];
    lda_con = '{16'h5E07, 16'hBE07, 16'h2607, 16'h1A07, 16'h2C07, 16'h3E07};
    ring    = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};

    bus_if.run    = 1'b1;
    bus_if.step   = 1'b0;
    bus_if.opcode = 4'h0;
    CLR           = 1'b0;
    @(posedge CLK);
    #2;
    step_cycle();
    step_cycle();
    chk("reset_con", 32'(last_con), 32'h3E07);
    chk("reset_t_state", 32'(last_t), 32'h01);
    chk("reset_halted", 32'(last_h), 32'h0);

    // LDA free-run sequence and wrap into the next fetch
    CLR = 1'b1;
    run_instr(4'h0);
    for (int i = 0; i < 6; i++) begin
      chk("lda_con", 32'(got_con[i]), 32'(lda_con[i]));
      chk("lda_t_state", 32'(got_t[i]), 32'(ring[i]));
    end

    run_instr(4'h1);
    chk("add_wrap_con", 32'(got_con[0]), 32'h5E07);
    chk("add_wrap_t", 32'(got_t[0]), 32'h01);
    chk("add_t5", 32'(got_con[4]), 32'h2E03);
    chk("add_t6", 32'(got_con[5]), 32'h3C0F);

    run_instr(4'h2);
    chk("sub_t5", 32'(got_con[4]), 32'h2E03);
    chk("sub_t6", 32'(got_con[5]), 32'h3C1F);

    run_instr(4'hE);
    chk("out_t4", 32'(got_con[3]), 32'h3F06);
    chk("out_t5", 32'(got_con[4]), 32'h3E07);
    chk("out_t6", 32'(got_con[5]), 32'h3E07);

    run_instr(4'h7);
    chk("undef_t4", 32'(got_con[3]), 32'h3E07);
    chk("undef_t5", 32'(got_con[4]), 32'h3E07);
    chk("undef_t6", 32'(got_con[5]), 32'h3E07);

    // HLT: fetch still happens, then the sequencer freezes at T4
    run_instr(4'hF);
    chk("hlt_fetch", 32'(got_con[0]), 32'h5E07);
    chk("hlt_t4", 32'(got_con[3]), 32'h3E07);
    for (int i = 0; i < 22; i++) begin
      bus_if.step   = 1'($urandom_range(0, 1));
      bus_if.opcode = 4'($urandom_range(0, 15));
      step_cycle();
    end
    chk("hlt_halted", 32'(last_h), 32'h1);
    chk("hlt_t_state", 32'(last_t), 32'h08);
    chk("hlt_con", 32'(last_con), 32'h3E07);

    // Asynchronous reset in the middle of ADD T5
    bus_if.step = 1'b0;
    CLR = 1'b0;
    step_cycle();
    CLR = 1'b1;
    bus_if.opcode = 4'h1;
    for (int i = 0; i < 4; i++) step_cycle();
    chk("pre_async_t", 32'(bus_if.t_state), 32'h10);
    CLR = 1'b0;
    #1;
    chk("async_con", 32'(bus_if.con), 32'h3E07);
    chk("async_t_state", 32'(bus_if.t_state), 32'h01);
    chk("async_halted", 32'(bus_if.halted), 32'h0);
    step_cycle();
    CLR = 1'b1;
    step_cycle();
    chk("release_con", 32'(last_con), 32'h5E07);

    // Single-step from T2: stalled, then one 3-cycle pulse moves one T-state
    bus_if.run = 1'b0;
    for (int i = 0; i < 3; i++) step_cycle();
    chk("stall_con", 32'(last_con), 32'h3E07);
    chk("stall_t", 32'(last_t), 32'h02);
    bus_if.step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      sc[i] = last_con;
    end
    bus_if.step = 1'b0;
    step_cycle();
    chk("step_first", 32'(sc[0]), 32'hBE07);
    chk("step_second", 32'(sc[1]), 32'h3E07);
    chk("step_third", 32'(sc[2]), 32'h3E07);
    chk("step_t_after", 32'(last_t), 32'h04);

    // Randomized: mode switches, step noise, opcode churn, occasional reset
    for (int blk = 0; blk < 16; blk++) begin
      bus_if.run = 1'(blk % 2);
      for (int i = 0; i < 40; i++) begin
        CLR = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
        bus_if.step = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
        if ($urandom_range(0, 3) == 0) bus_if.opcode = 4'($urandom_range(0, 15));
        step_cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
